// File: rtl/sync_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkg
//   Shared constants and helpers for the sync_fifo block.
//   - FIFO_WIDTH_DEFAULT / FIFO_DEPTH_DEFAULT : default parameter values
//   - ptr_incr(ptr, depth) : wrap-around pointer increment. It works for any
//     depth, including depths that are not a power of two.
// ---------------------------------------------------------------------------
package sync_fifo_pkg;

    localparam int FIFO_WIDTH_DEFAULT = 16;
    localparam int FIFO_DEPTH_DEFAULT = 8;

    // The pointer wraps from depth-1 back to 0. The wrap is explicit, so
    // the pointer never indexes past the last entry of a non-pow2 array.
    function automatic int ptr_incr(input int ptr, input int depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// ---------------------------------------------------------------------------
// fifo_if
//   Handshake/data bundle between a FIFO producer/consumer and sync_fifo.
//   Parameter : FifoWidth - data word width
//   Signals   : data_in, wr_en, rd_en               (towards the FIFO)
//               data_out, wr_ack, overflow, underflow,
//               full, empty, almostfull, almostempty (from the FIFO)
//   Modports  : master - producer/consumer side
//               slave  - FIFO side
//               dut    - alias of slave, used by sync_fifo
// ---------------------------------------------------------------------------
interface fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int FifoWidth = FIFO_WIDTH_DEFAULT
);

    logic [FifoWidth-1:0] data_in;
    logic                 wr_en;
    logic                 rd_en;
    logic [FifoWidth-1:0] data_out;
    logic                 wr_ack;
    logic                 overflow;
    logic                 full;
    logic                 empty;
    logic                 almostfull;
    logic                 almostempty;
    logic                 underflow;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, full, empty,
               almostfull, almostempty, underflow
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, full, empty,
               almostfull, almostempty, underflow
    );

    modport dut (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, full, empty,
               almostfull, almostempty, underflow
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// ---------------------------------------------------------------------------
// sync_fifo_mem
//   Simple dual-port storage for sync_fifo: one synchronous write port and
//   one registered read port.
//   Ports:
//     i_clk    clock
//     i_rst    synchronous active-high reset (clears only the read register)
//     i_we     write enable
//     i_waddr  write address
//     i_wdata  write data
//     i_re     read enable; o_rdata holds its value while i_re=0
//     i_raddr  read address
//     o_rdata  registered read data
//   The storage array itself is never reset.
// ---------------------------------------------------------------------------
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int FifoWidth = FIFO_WIDTH_DEFAULT,
    parameter int FifoDepth = FIFO_DEPTH_DEFAULT,
    localparam int PtrW     = $clog2(FifoDepth)
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_we,
    input  logic [PtrW-1:0]      i_waddr,
    input  logic [FifoWidth-1:0] i_wdata,
    input  logic                 i_re,
    input  logic [PtrW-1:0]      i_raddr,
    output logic [FifoWidth-1:0] o_rdata
);

    logic [FifoWidth-1:0] r_mem [FifoDepth];
    logic [FifoWidth-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read returns the pre-edge contents. The FIFO never reads an entry that
    // is being written in the same cycle, so there is no collision to handle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered read data (1-cycle read latency),
//   a write acknowledge, overflow/underflow error pulses, and level flags.
//   Parameters : FifoWidth (>=1), FifoDepth (>=2; any value, not only pow2)
//   Ports:
//     clk_i    clock
//     rst_i    synchronous active-high reset
//     bus      fifo_if.dut: data_in/wr_en/rd_en in;
//              data_out, wr_ack, overflow, underflow (registered) and
//              full, empty, almostfull, almostempty (from count) out
//     count_o  occupancy count; present only when SYNC_FIFO_COUNT_EN is
//              defined
//   Optional feature macro: SYNC_FIFO_COUNT_EN
// ---------------------------------------------------------------------------
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int FifoWidth = FIFO_WIDTH_DEFAULT,
    parameter int FifoDepth = FIFO_DEPTH_DEFAULT,
    localparam int PtrW     = $clog2(FifoDepth),
    localparam int CntW     = $clog2(FifoDepth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
`ifdef SYNC_FIFO_COUNT_EN
    output logic [CntW-1:0] count_o,
`endif
    fifo_if.dut             bus
);

    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            r_wr_ack;
    logic            r_overflow;
    logic            r_underflow;

    logic            w_full;
    logic            w_empty;
    logic            w_wr_acc;
    logic            w_rd_acc;

    // All flags come from the count alone. With FifoDepth=2, almostfull and
    // almostempty are both set at count 1.
    assign w_full  = (r_count == CntW'(FifoDepth));
    assign w_empty = (r_count == '0);

    // Acceptance is decided on the pre-edge state. When the FIFO is full, a
    // read still frees an entry, but the write in the same cycle is rejected.
    assign w_wr_acc = bus.wr_en & ~w_full;
    assign w_rd_acc = bus.rd_en & ~w_empty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= bus.wr_en & w_full;
            r_underflow <= bus.rd_en & w_empty;

            if (w_wr_acc) begin
                r_wr_ptr <= PtrW'(ptr_incr(int'(r_wr_ptr), FifoDepth));
            end
            if (w_rd_acc) begin
                r_rd_ptr <= PtrW'(ptr_incr(int'(r_rd_ptr), FifoDepth));
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Reset blocks the write strobe, so an operation in flight when reset
    // arrives does not reach the storage array.
    sync_fifo_mem #(
        .FifoWidth (FifoWidth),
        .FifoDepth (FifoDepth)
    ) u_mem (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_we    (w_wr_acc & ~rst_i),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.data_in),
        .i_re    (w_rd_acc),
        .i_raddr (r_rd_ptr),
        .o_rdata (bus.data_out)
    );

    assign bus.wr_ack      = r_wr_ack;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almostfull  = (r_count == CntW'(FifoDepth - 1));
    assign bus.almostempty = (r_count == CntW'(1));

`ifdef SYNC_FIFO_COUNT_EN
    assign count_o = r_count;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo
//   Directed self-checking bench for sync_fifo with FifoWidth=16 and
//   FifoDepth=8. Inputs change 1 time unit after a rising edge. Outputs are
//   sampled 1 time unit after the following rising edge. When
//   SYNC_FIFO_COUNT_EN is defined, count_o is also checked.
// ---------------------------------------------------------------------------
module tb_sync_fifo;

    localparam int W = 16;
    localparam int D = 8;
    localparam int CW = $clog2(D + 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    fifo_if #(.FifoWidth(W)) bus ();

`ifdef SYNC_FIFO_COUNT_EN
    logic [CW-1:0] count_o;
`endif

    sync_fifo #(.FifoWidth(W), .FifoDepth(D)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
`ifdef SYNC_FIFO_COUNT_EN
        .count_o (count_o),
`endif
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Applies one cycle of stimulus and returns 1 time unit after the edge.
    task automatic cyc(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
        rst          = r;
        bus.wr_en    = w;
        bus.rd_en    = rd;
        bus.data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_cnt(input string tag, input int exp);
`ifdef SYNC_FIFO_COUNT_EN
        chk(tag, 32'(count_o), 32'(exp));
`else
        // Without count_o, the occupancy is checked through the flags instead.
        chk({tag, "_empty"}, 32'(bus.empty), 32'(exp == 0));
        chk({tag, "_full"},  32'(bus.full),  32'(exp == D));
`endif
    endtask

    task automatic chk_flags(input string tag, input logic f, input logic e,
                             input logic af, input logic ae);
        chk({tag, "_full"},  32'(bus.full),        32'(f));
        chk({tag, "_empty"}, 32'(bus.empty),       32'(e));
        chk({tag, "_af"},    32'(bus.almostfull),  32'(af));
        chk({tag, "_ae"},    32'(bus.almostempty), 32'(ae));
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.data_in = '0;
        #2;

        // Reset for 2 cycles while both requests are held high.
        cyc(1, 1, 1, 16'hFFFF);
        cyc(1, 1, 1, 16'hFFFF);
        chk_flags("rst", 0, 1, 0, 0);
        chk("rst_dout", 32'(bus.data_out), 0);
        chk("rst_wack", 32'(bus.wr_ack), 0);
        chk("rst_ovf",  32'(bus.overflow), 0);
        chk("rst_udf",  32'(bus.underflow), 0);
        chk_cnt("rst_cnt", 0);

        // Fill the FIFO with 0x0001 through 0x0008.
        for (int i = 1; i <= D; i++) begin
            cyc(0, 1, 0, 16'(i));
            chk("fill_wack", 32'(bus.wr_ack), 1);
            chk_flags("fill", i == D, 0, i == D-1, i == 1);
            chk_cnt("fill_cnt", i);
        end
        // A 9th write is rejected.
        cyc(0, 1, 0, 16'h0009);
        chk("ovf", 32'(bus.overflow), 1);
        chk("ovf_wack", 32'(bus.wr_ack), 0);
        chk_cnt("ovf_cnt", D);

        // Drain the FIFO. The data must come out in the order it was written.
        for (int i = 1; i <= D; i++) begin
            cyc(0, 0, 1, '0);
            chk("drain_dout", 32'(bus.data_out), 32'(i));
            chk("drain_udf", 32'(bus.underflow), 0);
            chk("drain_ovf", 32'(bus.overflow), 0);
            chk_flags("drain", 0, i == D, i == 1, i == D-1);
        end
        // A 9th read is rejected, and data_out holds its value.
        cyc(0, 0, 1, '0);
        chk("udf", 32'(bus.underflow), 1);
        chk("udf_dout", 32'(bus.data_out), 32'h0008);
        cyc(0, 0, 0, '0);
        chk("udf_clr", 32'(bus.underflow), 0);
        chk("idle_dout", 32'(bus.data_out), 32'h0008);

        // Wrap: 5 in and 5 out move both pointers to 5. Then 6 more words
        // cross the end of the array.
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 16'hB000 + 16'(i));
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1, '0);
            chk("wrap1_dout", 32'(bus.data_out), 32'hB000 + 32'(i));
        end
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 16'hA000 + 16'(i));
        chk_cnt("wrap_cnt", 6);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 1, '0);
            chk("wrap2_dout", 32'(bus.data_out), 32'hA000 + 32'(i));
        end
        chk_flags("wrap_end", 0, 1, 0, 0);

        // Simultaneous read and write at count 4.
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 16'hC000 + 16'(i));
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 16'hC004 + 16'(i));
            chk("sim_wack", 32'(bus.wr_ack), 1);
            chk("sim_dout", 32'(bus.data_out), 32'hC000 + 32'(i));
            chk_cnt("sim_cnt", 4);
            chk_flags("sim", 0, 0, 0, 0);
        end
        // The FIFO now holds C003..C006. Add C007..C00A to make it full.
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 16'hC007 + 16'(i));
        chk("simf_full", 32'(bus.full), 1);
        // When full, only the read is accepted.
        cyc(0, 1, 1, 16'hDEAD);
        chk("simf_ovf", 32'(bus.overflow), 1);
        chk("simf_wack", 32'(bus.wr_ack), 0);
        chk("simf_dout", 32'(bus.data_out), 32'hC003);
        chk_flags("simf", 0, 0, 1, 0);
        chk_cnt("simf_cnt", 7);
        for (int i = 0; i < 7; i++) begin
            cyc(0, 0, 1, '0);
            chk("simf_drain", 32'(bus.data_out), 32'hC004 + 32'(i));
        end
        // When empty, only the write is accepted, and its data is not bypassed
        // to data_out.
        cyc(0, 1, 1, 16'hE000);
        chk("sime_udf", 32'(bus.underflow), 1);
        chk("sime_wack", 32'(bus.wr_ack), 1);
        chk("sime_dout", 32'(bus.data_out), 32'hC00A);
        chk_flags("sime", 0, 0, 0, 1);
        chk_cnt("sime_cnt", 1);
        cyc(0, 0, 1, '0);
        chk("sime_rd", 32'(bus.data_out), 32'hE000);

        // Reset in mid-operation, at count 5, with a write pending.
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 16'hF000 + 16'(i));
        chk_cnt("mid_cnt", 5);
        cyc(1, 1, 0, 16'h1234);
        chk_flags("midrst", 0, 1, 0, 0);
        chk("midrst_wack", 32'(bus.wr_ack), 0);
        chk("midrst_dout", 32'(bus.data_out), 0);
        chk_cnt("midrst_cnt", 0);
        cyc(0, 0, 1, '0);
        chk("midrst_udf", 32'(bus.underflow), 1);
        chk("midrst_dout2", 32'(bus.data_out), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock synchronous FIFO with registered read data.
- Provides write acknowledge, overflow/underflow error pulses, and full/empty/almost-full/almost-empty level flags.
- Used as a generic buffering block between a producer and a consumer in the same clock domain.
- Its port set matches the dut modport of fifo_if.

Parameters:
- FifoWidth, 16, data word width in bits (>=1).
- FifoDepth, 8, number of storage entries (>=2; need not be a power of two).

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- data_in  input  FifoWidth  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  FifoWidth  registered read data.
- wr_ack  output  1  registered; 1 for one cycle after an accepted write.
- overflow  output  1  registered; 1 for one cycle after a write rejected because the FIFO was full.
- full  output  1  combinational; count == FifoDepth.
- empty  output  1  combinational; count == 0.
- almostfull  output  1  combinational; count == FifoDepth-1.
- almostempty  output  1  combinational; count == 1.
- underflow  output  1  registered; 1 for one cycle after a read rejected because the FIFO was empty.

Behaviour:
- State:
  - Write pointer wr_ptr and read pointer rd_ptr, each $clog2(FifoDepth) bits.
  - Occupancy count, $clog2(FifoDepth+1) bits.
  - Storage array of FifoDepth x FifoWidth.
- Reset (rst_i=1 at a clock edge):
  - wr_ptr, rd_ptr and count become 0.
  - data_out, wr_ack, overflow and underflow become 0.
  - Storage contents are not cleared.
  - After reset: empty=1, full=0, almostfull=0, almostempty=0.
  - Reset has priority over any wr_en/rd_en in the same cycle; an in-flight operation is discarded.
- Write acceptance: accepted when wr_en=1 and full=0, evaluated on the pre-edge state.
  - mem[wr_ptr] <= data_in.
  - wr_ptr advances, wrapping from FifoDepth-1 to 0.
  - wr_ack <= 1.
- Write rejection: when wr_en=1 and full=1, no storage change, wr_ack <= 0, overflow <= 1.
- Otherwise wr_ack <= 0 and overflow <= 0.
- Read acceptance: accepted when rd_en=1 and empty=0.
  - data_out <= mem[rd_ptr], valid the cycle after the request (1-cycle latency).
  - rd_ptr advances with wrap.
  - underflow <= 0.
- Read rejection: when rd_en=1 and empty=1, underflow <= 1 and data_out holds its value.
- Otherwise underflow <= 0 and data_out holds.
- Simultaneous wr_en and rd_en:
  - Neither full nor empty: both accepted, count unchanged.
  - Full: read accepted, write rejected (overflow=1), count decrements.
  - Empty: write accepted, read rejected (underflow=1), count increments. Written data is not bypassed to data_out.
- Count update: +1 for a write-only accept, -1 for a read-only accept, 0 when both or neither are accepted. Count never leaves the range 0..FifoDepth.
- Flags derive solely from count. With FifoDepth=2, almostfull and almostempty are both 1 when count==1.

Optional Feature:
- Macro SYNC_FIFO_COUNT_EN.
- When defined:
  - Adds output port count_o, width $clog2(FifoDepth+1), driven directly from the internal occupancy count.
  - count_o is 0 after reset and equals the number of stored entries at all times.
- When undefined:
  - The port does not exist.
  - The count register still exists internally for flag generation.
  - Behaviour is otherwise identical.

Decomposition:
- Package sync_fifo_pkg:
  - Default constants FIFO_WIDTH_DEFAULT=16 and FIFO_DEPTH_DEFAULT=8.
  - Helper function ptr_incr(ptr, depth) for wrap-around increment.
- Sub-module sync_fifo_mem:
  - Simple dual-port storage array with one synchronous write port and one registered read port.
  - Parameterised by FifoWidth and FifoDepth.
- sync_fifo holds the pointers, count, handshake and flag logic.

Test Plan:
- Reset: assert rst_i for 2 cycles while wr_en=rd_en=1 -> empty=1, full=0, data_out=0, wr_ack=0, overflow=0, underflow=0.
- Fill: write 0x0001..0x0008 on consecutive cycles -> wr_ack=1 after each write; almostfull=1 after the 7th write; full=1 after the 8th. A 9th write (0x0009) -> overflow=1, wr_ack=0, contents unchanged.
- Drain: read 8 times -> data_out = 0x0001..0x0008 in order, each one cycle after rd_en; almostempty=1 at count 1; empty=1 at the end. A 9th read -> underflow=1 and data_out stays 0x0008.
- Wrap: write 5 words, read 5, then write 6 words 0xA000..0xA005 -> pointers wrap and reads return 0xA000..0xA005 in order.
- Simultaneous: at count=4, assert wr_en=rd_en=1 for 3 cycles -> count stays 4 and wr_ack=1 each cycle. When full, wr_en=rd_en=1 -> one read, overflow=1, count=7. When empty, both asserted -> underflow=1, wr_ack=1, count=1.
- Mid-operation reset: with count=5, assert rst_i together with wr_en=1 -> next cycle empty=1, wr_ack=0. With SYNC_FIFO_COUNT_EN defined, count_o=0.
